// File: rtl/lcd_spi_fifo_tx.sv
// FIFO-buffered SPI transmitter for the LCD panel: queues byte/word writes and
// serialises them MSB-first with DCX, CSX, SDO and a divided SCK.
module lcd_spi_fifo_tx #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          CPOL       = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        load16,
  input  logic [15:0] in,
  output logic [15:0] out,
  output logic        DCX,
  output logic        CSX,
  output logic        SDO,
  output logic        SCK
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned ENT_W = 18;

  typedef enum logic [2:0] {IDLE, LO, HI, HOLD, GAP} state_t;

  state_t           state, state_n;
  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [3:0]       count;
  logic             overflow;
  logic [DIV_W-1:0] div, div_n;
  logic [3:0]       bitcnt, bitcnt_n;
  logic [15:0]      shreg, shreg_n;
  logic             dcx_n, csx_n, sdo_n, sck_n;
  logic             push, full, push_ok, pop, div_done;
  logic [ENT_W-1:0] wr_entry, head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Entry layout {dcx, is16, data}; a byte write takes priority over a word write.
  assign push     = load | load16;
  assign full     = (count == 4'(FIFO_DEPTH));
  assign push_ok  = push & ~full;
  assign wr_entry = load ? {in[9], 1'b0, 8'h00, in[7:0]} : {1'b1, 1'b1, in};
  assign head     = mem[rd_ptr];
  assign pop      = (state == IDLE) && (count != 4'd0);
  assign div_done = (div == DIV_W'(CLK_DIV - 1));
  assign out      = {(state != IDLE) || (count != 4'd0), full, overflow, 9'd0, count};

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_entry;
  end

  // Full is judged before the same-cycle pop, so a push while full is always dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= 4'd0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push && full) overflow <= 1'b1;
      if (push_ok && !pop) count <= count + 4'd1;
      else if (!push_ok && pop) count <= count - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      div    <= '0;
      bitcnt <= 4'd0;
      shreg  <= 16'd0;
      DCX    <= 1'b0;
      CSX    <= 1'b1;
      SDO    <= 1'b0;
      SCK    <= CPOL;
    end else begin
      state  <= state_n;
      div    <= div_n;
      bitcnt <= bitcnt_n;
      shreg  <= shreg_n;
      DCX    <= dcx_n;
      CSX    <= csx_n;
      SDO    <= sdo_n;
      SCK    <= sck_n;
    end
  end

  // SDO only moves together with SCK falling, keeping it stable across rising edges.
  always_comb begin
    state_n  = state;
    div_n    = div;
    bitcnt_n = bitcnt;
    shreg_n  = shreg;
    dcx_n    = DCX;
    csx_n    = CSX;
    sdo_n    = SDO;
    sck_n    = SCK;
    case (state)
      IDLE: begin
        if (pop) begin
          shreg_n  = head[16] ? head[15:0] : {head[7:0], 8'h00};
          bitcnt_n = head[16] ? 4'd15 : 4'd7;
          dcx_n    = head[17];
          sdo_n    = shreg_n[15];
          csx_n    = 1'b0;
          sck_n    = 1'b0;
          div_n    = '0;
          state_n  = LO;
        end
      end
      LO: begin
        if (div_done) begin
          div_n   = '0;
          sck_n   = 1'b1;
          state_n = HI;
        end else begin
          div_n = div + DIV_W'(1);
        end
      end
      HI: begin
        if (div_done) begin
          div_n = '0;
          if (bitcnt != 4'd0) begin
            sck_n    = 1'b0;
            sdo_n    = shreg[14];
            shreg_n  = {shreg[14:0], 1'b0};
            bitcnt_n = bitcnt - 4'd1;
            state_n  = LO;
          end else begin
            sck_n   = CPOL;
            state_n = HOLD;
          end
        end else begin
          div_n = div + DIV_W'(1);
        end
      end
      HOLD: begin
        if (div_done) begin
          div_n   = '0;
          csx_n   = 1'b1;
          state_n = GAP;
        end else begin
          div_n = div + DIV_W'(1);
        end
      end
      GAP: begin
        if (div_done) begin
          div_n   = '0;
          state_n = IDLE;
        end else begin
          div_n = div + DIV_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lcd_spi_fifo_tx.sv
// Scoreboard bench for lcd_spi_fifo_tx: default instance (CLK_DIV=2, CPOL=0)
// plus a CPOL=1, CLK_DIV=1 instance; a pin-level monitor decodes SPI frames.
module tb_lcd_spi_fifo_tx;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic        dcx;
    logic [4:0]  nbits;
    logic [15:0] data;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld   [2];
  logic        ld16 [2];
  logic [15:0] din  [2];
  logic [15:0] st   [2];
  logic        dcx_v[2], csx_v[2], sdo_v[2], sck_v[2];

  frame_t q0[$];
  frame_t q1[$];
  int     checks = 0;
  int     errors = 0;
  logic   ovf_seen[2];

  logic        act[2];
  int          low[2];
  int          nb[2];
  logic [15:0] sh[2];
  logic        dcx0[2];
  logic        dstable[2];
  logic        psck[2];

  int          bk[8];
  logic [15:0] bv[8];

  always #5 clk = ~clk;

  lcd_spi_fifo_tx #(.CLK_DIV(2), .FIFO_DEPTH(DEPTH), .CPOL(1'b0)) u_dut0 (
    .clk(clk), .reset(rst), .load(ld[0]), .load16(ld16[0]), .in(din[0]), .out(st[0]),
    .DCX(dcx_v[0]), .CSX(csx_v[0]), .SDO(sdo_v[0]), .SCK(sck_v[0])
  );

  lcd_spi_fifo_tx #(.CLK_DIV(1), .FIFO_DEPTH(DEPTH), .CPOL(1'b1)) u_dut1 (
    .clk(clk), .reset(rst), .load(ld[1]), .load16(ld16[1]), .in(din[1]), .out(st[1]),
    .DCX(dcx_v[1]), .CSX(csx_v[1]), .SDO(sdo_v[1]), .SCK(sck_v[1])
  );

  function automatic int div_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic logic cpol_of(input int i);
    return (i == 0) ? 1'b0 : 1'b1;
  endfunction

  // Kind 0 = load, 1 = load16, 2 = both (byte wins).
  function automatic frame_t model(input int kind, input logic [15:0] v);
    frame_t f;
    if (kind != 1) begin
      f.dcx = v[9]; f.nbits = 5'd8; f.data = {8'h00, v[7:0]};
    end else begin
      f.dcx = 1'b1; f.nbits = 5'd16; f.data = v;
    end
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic finish_frame(input int i);
    frame_t got, exp;
    got.dcx = dcx0[i]; got.nbits = 5'(nb[i]); got.data = sh[i];
    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
      check("unexpected_frame", 32'(got), 32'hFFFF_FFFF);
    end else begin
      exp = (i == 0) ? q0.pop_front() : q1.pop_front();
      check("frame", 32'(got), 32'(exp));
      check("csx_low_cycles", 32'(low[i]), 32'((2 * int'(exp.nbits) + 1) * div_of(i)));
      check("dcx_stable", 32'(dstable[i]), 32'd1);
      check("sck_idle_after", 32'(sck_v[i]), 32'(cpol_of(i)));
    end
  endtask

  // Decode pins: SDO is captured on each SCK rise seen while CSX is low.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        act[i]  = 1'b0;
        psck[i] = cpol_of(i);
      end else begin
        if (!csx_v[i]) begin
          if (!act[i]) begin
            act[i] = 1'b1; low[i] = 0; nb[i] = 0; sh[i] = 16'd0;
            dcx0[i] = dcx_v[i]; dstable[i] = 1'b1;
          end
          low[i]++;
          if (dcx_v[i] !== dcx0[i]) dstable[i] = 1'b0;
          if (sck_v[i] && !psck[i]) begin
            sh[i] = {sh[i][14:0], sdo_v[i]};
            nb[i]++;
          end
        end else if (act[i]) begin
          act[i] = 1'b0;
          finish_frame(i);
        end
        psck[i] = sck_v[i];
      end
    end
  end

  // k back-to-back single-cycle pushes from idle: one pops on the 2nd edge, DEPTH fit behind it.
  task automatic burst(input int inst, input int k);
    int cnt;
    for (int j = 0; j < k; j++) begin
      ld[inst]   = (bk[j] != 1);
      ld16[inst] = (bk[j] != 0);
      din[inst]  = bv[j];
      if (j <= int'(DEPTH)) begin
        if (inst == 0) q0.push_back(model(bk[j], bv[j]));
        else q1.push_back(model(bk[j], bv[j]));
      end
      @(posedge clk); #1;
    end
    ld[inst] = 1'b0; ld16[inst] = 1'b0;
    if (k > int'(DEPTH) + 1) ovf_seen[inst] = 1'b1;
    cnt = (k == 1) ? 1 : ((k - 1 > int'(DEPTH)) ? int'(DEPTH) : k - 1);
    check("status_after_burst", 32'(st[inst]),
          32'({1'b1, cnt == int'(DEPTH), ovf_seen[inst], 9'd0, 4'(cnt)}));
  endtask

  task automatic wait_idle(input int inst, input int budget);
    int n = 0;
    while (st[inst][15] && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_reached", 32'(st[inst][15]), 32'd0);
    check("all_frames_seen", 32'((inst == 0) ? q0.size() : q1.size()), 32'd0);
    check("status_idle", 32'(st[inst]), 32'({2'b00, ovf_seen[inst], 13'd0}));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int n, edges;
    logic p;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ld[i] = 1'b0; ld16[i] = 1'b0; din[i] = 16'd0; ovf_seen[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("reset_out", 32'(st[i]), 32'd0);
      check("reset_csx", 32'(csx_v[i]), 32'd1);
      check("reset_dcx", 32'(dcx_v[i]), 32'd0);
      check("reset_sdo", 32'(sdo_v[i]), 32'd0);
      check("reset_sck", 32'(sck_v[i]), 32'(cpol_of(i)));
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Byte with DCX from bit 9; pop lands one edge after the push.
    bk[0] = 0; bv[0] = 16'h022A;
    burst(0, 1);
    check("csx_before_pop", 32'(csx_v[0]), 32'd1);
    @(posedge clk); #1;
    check("csx_at_pop", 32'(csx_v[0]), 32'd0);
    check("dcx_at_pop", 32'(dcx_v[0]), 32'd1);
    wait_idle(0, 300);

    bk[0] = 1; bv[0] = 16'hF81F;
    burst(0, 1);
    wait_idle(0, 300);

    bk[0] = 2; bv[0] = 16'h0355;
    burst(0, 1);
    wait_idle(0, 300);

    for (int r = 0; r < 10; r++) begin
      int k;
      k = $urandom_range(1, 5);
      for (int j = 0; j < k; j++) begin
        bk[j] = $urandom_range(0, 2);
        bv[j] = 16'($urandom);
      end
      burst(0, k);
      wait_idle(0, 1000);
    end

    // Overfill: sixth push is dropped and overflow sticks.
    for (int j = 0; j < 6; j++) begin
      bk[j] = 0; bv[j] = 16'(j + 1);
    end
    burst(0, 6);
    wait_idle(0, 1000);

    // Asynchronous reset partway through a word.
    bk[0] = 1; bv[0] = 16'($urandom);
    burst(0, 1);
    n = 0;
    while (!(act[0] && nb[0] >= 5) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("reached_bit5", 32'(n < 300), 32'd1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("abort_csx", 32'(csx_v[0]), 32'd1);
    check("abort_sck", 32'(sck_v[0]), 32'd0);
    check("abort_sdo", 32'(sdo_v[0]), 32'd0);
    check("abort_out", 32'(st[0]), 32'd0);
    q0.delete();
    ovf_seen[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    edges = 0;
    p = sck_v[0];
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (sck_v[0] !== p || csx_v[0] !== 1'b1) edges++;
      p = sck_v[0];
    end
    check("quiet_after_reset", 32'(edges), 32'd0);
    @(posedge clk); #1;

    for (int j = 0; j < 3; j++) begin
      bk[j] = $urandom_range(0, 2);
      bv[j] = 16'($urandom);
    end
    burst(0, 3);
    wait_idle(0, 1000);

    // CPOL=1, CLK_DIV=1 instance: SCK idles high and falls at the pop edge.
    check("cpol1_idle_sck", 32'(sck_v[1]), 32'd1);
    bk[0] = 0; bv[0] = 16'h0081;
    burst(1, 1);
    @(posedge clk); #1;
    check("cpol1_sck_at_pop", 32'(sck_v[1]), 32'd0);
    check("cpol1_csx_at_pop", 32'(csx_v[1]), 32'd0);
    wait_idle(1, 200);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
